alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_alu.sv | 23 ++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared FSM encoding, ALU function codes and operand record for the ALU arbiter.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] SLT = 6'b101010;

    typedef struct packed {
        logic [31:0] data_a;
        logic [31:0] data_b;
        logic [5:0]  signal;
        logic        id;
    } op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 32-bit ALU: add, subtract, signed set-less-than; unknown codes take the sum path.
// Latency: purely combinational.
// Backpressure: none, operands are held by the caller.
module ALU
    import alu_arbiter_pkg::*;
(
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic [5:0]  signal,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = data_a + data_b;
        case (signal)
            ADD:     data_out = data_a + data_b;
            SUB:     data_out = data_a - data_b;
            SLT:     data_out = {31'd0, ($signed(data_a) < $signed(data_b))};
            default: data_out = data_a + data_b;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Latency: result valid EXEC_CYCLES+1 cycles after the operand transfer.
// Backpressure: result held until resp_ready; no new grant until it drains.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_dataA,
    input  logic [31:0] req0_dataB,
    input  logic [5:0]  req0_Signal,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_dataA,
    input  logic [31:0] req1_dataB,
    input  logic [5:0]  req1_Signal,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data
);

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic        ptr;
    logic [3:0]  cnt;
    op_t         op_q;
    op_t         op_in;
    logic        any_valid;
    logic        grant_id;
    logic        take;
    logic [31:0] alu_out;

    // Pointer names the favoured requester; fall back to the other when it is idle.
    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (ptr ? req1_valid : req0_valid) ? ptr : ~ptr;
    assign take      = (state == IDLE) && any_valid;

    always_comb begin
        op_in = '0;
        if (grant_id) begin
            op_in.data_a = req1_dataA;
            op_in.data_b = req1_dataB;
            op_in.signal = req1_Signal;
            op_in.id     = 1'b1;
        end else begin
            op_in.data_a = req0_dataA;
            op_in.data_b = req0_dataB;
            op_in.signal = req0_Signal;
            op_in.id     = 1'b0;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt  = EXEC;
                    // Gated by reset so every output reads zero while reset is held.
                    req0_ready = reset & ~grant_id;
                    req1_ready = reset & grant_id;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= 1'b0;
            cnt       <= 4'd0;
            op_q      <= '0;
            resp_data <= 32'd0;
            resp_id   <= 1'b0;
        end else begin
            if (take) begin
                op_q <= op_in;
                ptr  <= ~grant_id;
                cnt  <= CNT_LOAD;
            end else if (state == EXEC) begin
                if (cnt == 4'd0) begin
                    resp_data <= alu_out;
                    resp_id   <= op_q.id;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    ALU u_alu (
        .data_a   (op_q.data_a),
        .data_b   (op_q.data_b),
        .signal   (op_q.signal),
        .data_out (alu_out)
    );

endmodule
